can_rx_loader: RTL
==================

Name: can_rx_loader

Overview:
- Upstream write stage for the receive FIFO controller.
- Takes the received-frame byte stream from the CAN bit-stream processor and writes each byte into the current FIFO input slot through the port-b interface: b_addr, b_din, b_wrn and dsc_in.
- Commits a frame with a one-cycle b_next pulse only if it ends correctly and passes acceptance and length checks. Otherwise the partial frame is abandoned and the slot is reused.

Parameters:
- P_BUF_BYTES, 10, byte capacity of one FIFO slot (2 descriptor bytes + 8 data bytes). Legal range 3..16.
- P_MIN_BYTES, 2, minimum byte count for a committable frame (the descriptor bytes).

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- rx_sof  in  1  start-of-frame pulse from the bit-stream processor
- rx_byte_valid  in  1  one-cycle strobe; rx_byte is valid
- rx_byte  in  8  received byte, in frame order
- rx_dsc  in  2  frame descriptor bits, valid with rx_sof
- rx_eof_ok  in  1  pulse: frame ended without error
- rx_error  in  1  pulse: frame aborted (bit/stuff/CRC/form error)
- acc_match  in  1  acceptance filter result, valid with rx_eof_ok
- b_addr  out  4  byte address within the slot
- b_din  out  8  write data
- b_wrn  out  1  write strobe, active low
- b_next  out  1  commit pulse, advances the FIFO input slot
- dsc_in  out  2  descriptor bits, held for the whole frame
- rx_busy  out  1  frame in progress
- frame_stored  out  1  pulse, coincident with b_next
- frame_dropped  out  1  pulse, frame discarded

Behaviour:
- Reset values: b_addr=0, b_din=0, b_wrn=1, b_next=0, dsc_in=0, rx_busy=0, frame_stored=0, frame_dropped=0. State=IDLE, byte_cnt=0, len_err=0.
- All outputs are registered.
- States: IDLE, LOAD, CHECK, COMMIT.
- IDLE:
  - rx_sof -> LOAD; byte_cnt=0, len_err=0, dsc_in<=rx_dsc.
  - rx_byte_valid, rx_eof_ok and rx_error are ignored.
- LOAD:
  - rx_busy=1.
  - rx_byte_valid at cycle n with byte_cnt<P_BUF_BYTES: at n+1, b_addr=byte_cnt, b_din=rx_byte, b_wrn=0 for exactly one cycle; byte_cnt increments.
  - rx_byte_valid with byte_cnt==P_BUF_BYTES: byte is not written, len_err=1, byte_cnt saturates.
  - b_addr and b_din hold their last values while b_wrn=1.
  - rx_error -> IDLE. frame_dropped pulses at n+1; no b_next.
  - rx_sof while in LOAD: restart. byte_cnt=0, len_err=0, dsc_in reloaded, frame_dropped pulses. Earlier slot contents are overwritten in place.
  - rx_eof_ok -> CHECK. A simultaneous rx_byte_valid is written and counted first. acc_match is latched on rx_eof_ok.
  - rx_error has priority over rx_eof_ok if both are set; rx_sof has priority over both.
- CHECK, one cycle:
  - Pass requires acc_match=1, len_err=0 and byte_cnt>=P_MIN_BYTES.
  - Pass -> COMMIT.
  - Fail -> IDLE with a frame_dropped pulse.
- COMMIT, one cycle:
  - b_next=1 and frame_stored=1, then -> IDLE.
  - Latency: rx_eof_ok at cycle n gives b_next high at cycle n+2. The last b_wrn low is always at least one cycle before b_next.
- dsc_in is held constant from rx_sof until the cycle after b_next or drop. The status buffer stores it on each b_wrn.
- FIFO full/overflow is not examined. Overwrite and overflow reporting belong to the FIFO controller; the loader always commits.
- Back-to-back frames:
  - rx_sof during CHECK or COMMIT is accepted: the state after COMMIT or drop is LOAD, not IDLE.
  - The pending commit or drop completes first.
- nreset mid-frame: all outputs return to reset values immediately; no b_next is issued.

Optional Feature:
- Macro: CAN_RX_DLC_CHECK_EN.
- Defined:
  - Byte 1 is captured as {id[2:0], rtr, dlc[3:0]}.
  - Expected count = 2 if rtr=1, otherwise 2+min(dlc,8).
  - In CHECK, byte_cnt != expected fails the frame (frame_dropped, no b_next).
- Not defined: no DLC capture or compare; the pass condition is as above.

Test Plan:
- Data frame: rx_sof, rx_dsc=2'b10, 10 bytes 0x11..0x1A, rx_eof_ok with acc_match=1 -> b_wrn low 10 times at addr 0..9 with matching data, dsc_in=2'b10 throughout, b_next and frame_stored high 2 cycles after rx_eof_ok.
- Acceptance reject: same frame with acc_match=0 -> 10 writes, no b_next, frame_dropped one pulse.
- Error abort: rx_sof, 4 bytes, rx_error -> 4 writes, frame_dropped, IDLE; a following valid 3-byte frame commits with b_addr starting at 0.
- Overlength: 12 bytes -> only 10 writes (addr 0..9), frame dropped at CHECK.
- Simultaneous last byte and rx_eof_ok at cycle n -> write at n+1, b_next at n+2. Then nreset asserted mid-frame on the next frame -> b_wrn=1, b_next never pulses.
- With CAN_RX_DLC_CHECK_EN: byte1=0x05 with 7 bytes total -> committed; with 6 bytes -> dropped. Byte1=0x15 (rtr=1) with 2 bytes -> committed.

Source files
------------

// File: rtl/can_rx_loader.sv
// ---------------------------------------------------------------------------
// can_rx_loader
//
// Upstream write stage of the CAN receive FIFO controller. Bytes of the frame
// being received are written one at a time into the current FIFO input slot
// through the port-b interface. A frame that ends cleanly and passes the
// acceptance and length checks is committed with a one-cycle b_next pulse.
// Any other frame is abandoned, and its slot is reused by the next frame.
//
// Optional feature (compile-time macro CAN_RX_DLC_CHECK_EN):
//   Byte 1 is captured as {id[2:0], rtr, dlc[3:0]}. The frame must then
//   contain exactly 2 bytes if rtr=1, otherwise 2+min(dlc,8) bytes.
//
// Parameters:
//   P_BUF_BYTES   byte capacity of one FIFO slot (3..16)
//   P_MIN_BYTES   minimum byte count for a committable frame
//
// Ports:
//   clk, nreset      clock, asynchronous active-low reset
//   rx_sof           start-of-frame pulse; rx_dsc is valid with it
//   rx_byte_valid    one-cycle strobe qualifying rx_byte
//   rx_byte          received byte, in frame order
//   rx_dsc           frame descriptor bits
//   rx_eof_ok        frame ended without error; acc_match is valid with it
//   rx_error         frame aborted
//   acc_match        acceptance filter result
//   b_addr/b_din     slot byte address / write data
//   b_wrn            write strobe, active low
//   b_next           commit pulse, advances the FIFO input slot
//   dsc_in           descriptor bits, held for the whole frame
//   rx_busy          a frame is in progress
//   frame_stored     pulse, coincident with b_next
//   frame_dropped    pulse, frame discarded
// ---------------------------------------------------------------------------
module can_rx_loader #(
    parameter int P_BUF_BYTES = 10,
    parameter int P_MIN_BYTES = 2
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       rx_sof,
    input  logic       rx_byte_valid,
    input  logic [7:0] rx_byte,
    input  logic [1:0] rx_dsc,
    input  logic       rx_eof_ok,
    input  logic       rx_error,
    input  logic       acc_match,
    output logic [3:0] b_addr,
    output logic [7:0] b_din,
    output logic       b_wrn,
    output logic       b_next,
    output logic [1:0] dsc_in,
    output logic       rx_busy,
    output logic       frame_stored,
    output logic       frame_dropped
);

    localparam logic [4:0] BUF_BYTES = 5'(P_BUF_BYTES);
    localparam logic [4:0] MIN_BYTES = 5'(P_MIN_BYTES);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

    state_t     state;
    logic [4:0] byte_cnt;   // saturates at BUF_BYTES
    logic       len_err;    // a byte arrived with the slot already full
    logic       acc_lat;    // acceptance result latched on rx_eof_ok
    // A start-of-frame seen during CHECK/COMMIT is parked here, so the
    // current descriptor stays on dsc_in until the commit or drop is done.
    logic       sof_pend;
    logic [1:0] dsc_pend;
    logic       dlc_ok;
    logic       pass;

`ifdef CAN_RX_DLC_CHECK_EN
    logic       rtr_q;
    logic [3:0] dlc_q;
    logic [4:0] exp_cnt;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        exp_cnt = 5'd2;
        if (!rtr_q)
            exp_cnt = 5'd2 + ((dlc_q > 4'd8) ? 5'd8 : {1'b0, dlc_q});
    end

    assign dlc_ok = (byte_cnt == exp_cnt);
`else
    assign dlc_ok = 1'b1;
`endif

    assign pass = acc_lat && !len_err && (byte_cnt >= MIN_BYTES) && dlc_ok;

    // NOTE: sequential state uses non-blocking assignments only. When a
    // register is assigned twice in one pass, the later assignment wins,
    // and the LOAD branch relies on this to give rx_sof priority.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            len_err       <= 1'b0;
            acc_lat       <= 1'b0;
            sof_pend      <= 1'b0;
            dsc_pend      <= '0;
            b_addr        <= '0;
            b_din         <= '0;
            b_wrn         <= 1'b1;
            b_next        <= 1'b0;
            dsc_in        <= '0;
            rx_busy       <= 1'b0;
            frame_stored  <= 1'b0;
            frame_dropped <= 1'b0;
`ifdef CAN_RX_DLC_CHECK_EN
            rtr_q         <= 1'b0;
            dlc_q         <= '0;
`endif
        end else begin
            // Strobes and pulses are low unless a branch below raises them.
            b_wrn         <= 1'b1;
            b_next        <= 1'b0;
            frame_stored  <= 1'b0;
            frame_dropped <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_sof) begin
                        state    <= LOAD;
                        rx_busy  <= 1'b1;
                        byte_cnt <= '0;
                        len_err  <= 1'b0;
                        dsc_in   <= rx_dsc;
                    end
                end

                LOAD: begin
                    // Apply a descriptor parked by a drop from CHECK.
                    if (sof_pend) begin
                        dsc_in   <= dsc_pend;
                        sof_pend <= 1'b0;
                    end
                    if (rx_sof) begin
                        // Restart: the slot is rewritten from address 0.
                        byte_cnt      <= '0;
                        len_err       <= 1'b0;
                        dsc_in        <= rx_dsc;
                        frame_dropped <= 1'b1;
                    end else if (rx_error) begin
                        state         <= IDLE;
                        rx_busy       <= 1'b0;
                        frame_dropped <= 1'b1;
                    end else begin
                        if (rx_byte_valid) begin
                            if (byte_cnt < BUF_BYTES) begin
                                b_addr   <= byte_cnt[3:0];
                                b_din    <= rx_byte;
                                b_wrn    <= 1'b0;
                                byte_cnt <= byte_cnt + 5'd1;
`ifdef CAN_RX_DLC_CHECK_EN
                                if (byte_cnt == 5'd1) begin
                                    rtr_q <= rx_byte[4];
                                    dlc_q <= rx_byte[3:0];
                                end
`endif
                            end else begin
                                len_err <= 1'b1;
                            end
                        end
                        // A byte arriving together with rx_eof_ok is counted
                        // above, before CHECK looks at byte_cnt.
                        if (rx_eof_ok) begin
                            state   <= CHECK;
                            acc_lat <= acc_match;
                        end
                    end
                end

                CHECK: begin
                    if (rx_sof) begin
                        sof_pend <= 1'b1;
                        dsc_pend <= rx_dsc;
                    end
                    if (pass) begin
                        state        <= COMMIT;
                        b_next       <= 1'b1;
                        frame_stored <= 1'b1;
                    end else begin
                        frame_dropped <= 1'b1;
                        if (rx_sof || sof_pend) begin
                            state    <= LOAD;
                            byte_cnt <= '0;
                            len_err  <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                end

                COMMIT: begin
                    if (rx_sof || sof_pend) begin
                        state    <= LOAD;
                        byte_cnt <= '0;
                        len_err  <= 1'b0;
                        dsc_in   <= rx_sof ? rx_dsc : dsc_pend;
                        sof_pend <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
